// File: rtl/bank_cmd_dispatch.sv
// bank_cmd_dispatch: routes incoming access commands into per-bank FIFOs by bank field
// and issues them one at a time to the bank scheduler through a round-robin arbiter.
module bank_cmd_dispatch #(
  parameter int NUM_BANKS = 8,
  parameter int DEPTH     = 4,
  parameter int CMD_W     = 34,
  parameter int DATA_W    = 128
) (
  input  logic                 clk,
  input  logic                 power_on_rst,
  input  logic                 valid,
  input  logic [CMD_W-1:0]     command,
  input  logic [DATA_W-1:0]    write_data,
  output logic [NUM_BANKS-1:0] ba_cmd_pm,
  output logic                 out_valid,
  output logic [CMD_W-1:0]     out_cmd,
  output logic [DATA_W-1:0]    out_wdata,
  input  logic                 out_ready,
  output logic                 idle,
  output logic                 ovf_err
);

  localparam int BW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int EW     = CMD_W + DATA_W;
  localparam int RW_BIT = 31;

  logic [EW-1:0] mem_q    [NUM_BANKS][DEPTH];
  logic [CW-1:0] count_q  [NUM_BANKS];
  logic [CW-1:0] count_d  [NUM_BANKS];
  logic [PW-1:0] wr_ptr_q [NUM_BANKS];
  logic [PW-1:0] wr_ptr_d [NUM_BANKS];
  logic [PW-1:0] rd_ptr_q [NUM_BANKS];
  logic [PW-1:0] rd_ptr_d [NUM_BANKS];
  logic [BW-1:0] rr_q, rr_d;
  logic          ovf_q, ovf_d;

  logic [BW-1:0]     push_bank;
  logic              push_ok;
  logic [DATA_W-1:0] push_wdata;
  logic [BW-1:0]     grant;
  logic              grant_found;
  logic              pop;

  function automatic logic [BW-1:0] scan_bank(input logic [BW-1:0] start, input int offset);
    return BW'((int'(start) + offset) % NUM_BANKS);
  endfunction

  always_comb begin
    idle = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      ba_cmd_pm[b] = (count_q[b] != CW'(DEPTH));
      if (count_q[b] != '0) idle = 1'b0;
    end
  end

  assign push_bank  = command[BW-1:0];
  assign push_ok    = valid && ba_cmd_pm[push_bank];
  assign push_wdata = command[RW_BIT] ? '0 : write_data;

  // First non-empty bank at or after the round-robin pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!grant_found && count_q[scan_bank(rr_q, i)] != '0) begin
        grant_found = 1'b1;
        grant       = scan_bank(rr_q, i);
      end
    end
  end

  assign out_valid            = grant_found;
  assign {out_cmd, out_wdata} = grant_found ? mem_q[grant][rd_ptr_q[grant]] : '0;
  assign pop                  = grant_found && out_ready;
  assign ovf_err              = ovf_q;

  // NOTE: next-state logic is combinational with every output defaulted first, so no latches
  // are inferred; blocking assignments belong here, non-blocking only in the always_ff blocks.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_d     = rr_q;
    ovf_d    = ovf_q | (valid & ~push_ok);
    if (push_ok) begin
      wr_ptr_d[push_bank] = wr_ptr_q[push_bank] + PW'(1);
      count_d[push_bank]  = count_d[push_bank] + CW'(1);
    end
    if (pop) begin
      rd_ptr_d[grant] = rd_ptr_q[grant] + PW'(1);
      count_d[grant]  = count_d[grant] - CW'(1);
      rr_d            = (grant == BW'(NUM_BANKS - 1)) ? '0 : grant + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      count_q  <= '{default: '0};
      wr_ptr_q <= '{default: '0};
      rd_ptr_q <= '{default: '0};
      rr_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: entry storage has no reset; an entry is only read while its bank count covers it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[push_bank][wr_ptr_q[push_bank]] <= {command, push_wdata};
  end

endmodule

// File: tb/tb_bank_cmd_dispatch.sv
// Scoreboard bench for bank_cmd_dispatch: a monitor compares every cycle against
// per-bank expected queues and a round-robin reference; stimulus is directed plus random.
module tb_bank_cmd_dispatch;

  localparam int NB    = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         power_on_rst = 1'b1;
  logic         valid = 1'b0;
  logic [33:0]  command = '0;
  logic [127:0] write_data = '0;
  logic         out_ready = 1'b0;
  logic [7:0]   ba_cmd_pm;
  logic         out_valid;
  logic [33:0]  out_cmd;
  logic [127:0] out_wdata;
  logic         idle;
  logic         ovf_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [161:0] mq [NB][$];
  int           m_rr  = 0;
  bit           m_ovf = 1'b0;
  int           grant_log [$];

  always #5 clk = ~clk;

  bank_cmd_dispatch dut (
    .clk          (clk),
    .power_on_rst (power_on_rst),
    .valid        (valid),
    .command      (command),
    .write_data   (write_data),
    .ba_cmd_pm    (ba_cmd_pm),
    .out_valid    (out_valid),
    .out_cmd      (out_cmd),
    .out_wdata    (out_wdata),
    .out_ready    (out_ready),
    .idle         (idle),
    .ovf_err      (ovf_err)
  );

  task automatic check(input string name, input logic [161:0] act, input logic [161:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] mk_cmd(input logic [1:0] rank, input bit rw,
                                         input logic [12:0] row, input logic [9:0] col,
                                         input logic [2:0] bank);
    return {rank, rw, 1'b0, row, 1'b0, 1'b0, 1'b0, 1'b0, col, bank};
  endfunction

  function automatic logic [33:0] rand_cmd(input logic [2:0] bank);
    return mk_cmd(2'($urandom), 1'($urandom), 13'($urandom), 10'($urandom), bank);
  endfunction

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares DUT outputs mid-cycle, then applies the coming edge to the model.
  initial begin
    @(posedge clk);
    forever begin
      bit           exp_valid;
      int           g;
      logic [161:0] exp_entry;
      logic [7:0]   exp_pm;
      bit           exp_idle;
      bit           pushing;
      int           pb;
      @(negedge clk);
      exp_valid = 1'b0;
      g         = 0;
      exp_idle  = 1'b1;
      for (int i = 0; i < NB; i++) begin
        int k;
        k = (m_rr + i) % NB;
        if (!exp_valid && mq[k].size() != 0) begin
          exp_valid = 1'b1;
          g         = k;
        end
        exp_pm[i] = (mq[i].size() != DEPTH);
        if (mq[i].size() != 0) exp_idle = 1'b0;
      end
      exp_entry = exp_valid ? mq[g][0] : '0;
      check("out_valid", out_valid, exp_valid);
      check("out_cmd", out_cmd, exp_entry[161:128]);
      check("out_wdata", out_wdata, exp_entry[127:0]);
      check("ba_cmd_pm", ba_cmd_pm, exp_pm);
      check("idle", idle, exp_idle);
      check("ovf_err", ovf_err, m_ovf);

      if (power_on_rst) begin
        for (int b = 0; b < NB; b++) mq[b].delete();
        m_rr  = 0;
        m_ovf = 1'b0;
      end else begin
        pb      = int'(command[2:0]);
        pushing = valid && (mq[pb].size() < DEPTH);
        if (valid && !pushing) m_ovf = 1'b1;
        if (exp_valid && out_ready) begin
          void'(mq[g].pop_front());
          m_rr = (g + 1) % NB;
          grant_log.push_back(g);
        end
        if (pushing) mq[pb].push_back({command, command[31] ? 128'h0 : write_data});
      end
    end
  end

  task automatic drive(input bit v, input logic [33:0] c, input logic [127:0] d, input bit r);
    valid      = v;
    command    = c;
    write_data = d;
    out_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!idle && n < budget) begin
      drive(1'b0, '0, '0, 1'b1);
      n++;
    end
    check("drain_idle", idle, 1'b1);
  endtask

  task automatic reset_cycles(input int n);
    power_on_rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, '0, 1'b0);
      check("rst_pm", ba_cmd_pm, 8'hFF);
      check("rst_valid", out_valid, 1'b0);
      check("rst_idle", idle, 1'b1);
      check("rst_ovf", ovf_err, 1'b0);
    end
    power_on_rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_cycles(3);

    // Fill bank 2, overflow it, then drain in order.
    for (int i = 0; i < 4; i++)
      drive(1'b1, mk_cmd(2'd1, 1'b0, 13'(i), 10'(i), 3'd2), 128'hA0 + 128'(i), 1'b0);
    check("full_b2_pm", ba_cmd_pm, 8'hFB);
    check("full_b2_ovf0", ovf_err, 1'b0);
    drive(1'b1, mk_cmd(2'd1, 1'b0, 13'd4, 10'd4, 3'd2), 128'hA4, 1'b0);
    check("ovf_set", ovf_err, 1'b1);
    grant_log.delete();
    drain(20);
    check("b2_pops", 162'(grant_log.size()), 162'd4);

    // Read burst to banks 0,1,3,7 with ready held high.
    grant_log.delete();
    drive(1'b1, mk_cmd(2'd0, 1'b1, 13'd10, 10'd1, 3'd0), rand_data(), 1'b1);
    drive(1'b1, mk_cmd(2'd1, 1'b1, 13'd11, 10'd2, 3'd1), rand_data(), 1'b1);
    drive(1'b1, mk_cmd(2'd2, 1'b1, 13'd12, 10'd3, 3'd3), rand_data(), 1'b1);
    drive(1'b1, mk_cmd(2'd3, 1'b1, 13'd13, 10'd4, 3'd7), rand_data(), 1'b1);
    drain(20);
    check("burst_n", 162'(grant_log.size()), 162'd4);
    if (grant_log.size() == 4) begin
      check("burst_g0", 162'(grant_log[0]), 162'd0);
      check("burst_g1", 162'(grant_log[1]), 162'd1);
      check("burst_g2", 162'(grant_log[2]), 162'd3);
      check("burst_g3", 162'(grant_log[3]), 162'd7);
    end

    // Pop bank 0 so the pointer sits at 1, then banks 0 and 1 compete.
    grant_log.delete();
    drive(1'b1, rand_cmd(3'd0), rand_data(), 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b1, rand_cmd(3'd0), rand_data(), 1'b0);
    drive(1'b1, rand_cmd(3'd1), rand_data(), 1'b0);
    drain(20);
    check("rr_n", 162'(grant_log.size()), 162'd3);
    if (grant_log.size() == 3) begin
      check("rr_first_b1", 162'(grant_log[1]), 162'd1);
      check("rr_then_b0", 162'(grant_log[2]), 162'd0);
    end

    // Full bank 5: push rejected while popping, then accepted next cycle.
    reset_cycles(1);
    for (int i = 0; i < 4; i++) drive(1'b1, rand_cmd(3'd5), rand_data(), 1'b0);
    check("full_b5_pm", ba_cmd_pm, 8'hDF);
    drive(1'b1, rand_cmd(3'd5), rand_data(), 1'b1);
    check("b5_reject_ovf", ovf_err, 1'b1);
    check("b5_pm_free", ba_cmd_pm[5], 1'b1);
    drive(1'b1, rand_cmd(3'd5), rand_data(), 1'b0);
    check("b5_refill_pm", ba_cmd_pm, 8'hDF);
    drain(20);

    // Mid-stream reset discards buffered commands.
    drive(1'b1, rand_cmd(3'd1), rand_data(), 1'b0);
    drive(1'b1, rand_cmd(3'd4), rand_data(), 1'b0);
    drive(1'b1, rand_cmd(3'd6), rand_data(), 1'b0);
    power_on_rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    power_on_rst = 1'b0;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_idle", idle, 1'b1);
    drive(1'b1, rand_cmd(3'd1), rand_data(), 1'b1);
    drive(1'b1, rand_cmd(3'd4), rand_data(), 1'b1);
    drain(20);

    // Random traffic, congested onto a few banks, with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] b;
      b            = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(2, 4));
      power_on_rst = ($urandom_range(0, 199) == 0);
      drive(1'($urandom), rand_cmd(b), rand_data(), ($urandom_range(0, 2) != 0));
    end
    power_on_rst = 1'b0;
    drain(60);
    drive(1'b0, '0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_cmd_dispatch.md
Name: bank_cmd_dispatch

Overview:
- Front-end stage of the memory controller, directly downstream of the command source.
- Accepts 34-bit access commands plus 128-bit write data, and buffers each command in a per-bank FIFO selected by the bank field.
- Drives per-bank ready flags back to the source on `ba_cmd_pm`.
- Issues buffered commands one at a time to the bank scheduler through a round-robin arbiter with a valid/ready handshake.

Parameters:
- NUM_BANKS, 8, number of bank FIFOs; equals the width of `ba_cmd_pm`.
- DEPTH, 4, entries per bank FIFO (power of two, ≥2).
- CMD_W, 34, command width.
- DATA_W, 128, write-data width (DQ_BITS*8).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- power_on_rst  in  1  reset; synchronous, active-high.
- valid  in  1  command strobe from source.
- command  in  CMD_W  {rank[33:32], rw[31] (0=write, 1=read), 0[30], row[29:17], 0[16], bl[15], 0[14], auto_pre[13], col[12:3], bank[2:0]}.
- write_data  in  DATA_W  write payload; sampled with command when rw=0, ignored (stored as 0) when rw=1.
- ba_cmd_pm  out  NUM_BANKS  bit b=1 when bank b FIFO can accept a command this cycle.
- out_valid  out  1  a granted command is presented.
- out_cmd  out  CMD_W  granted command.
- out_wdata  out  DATA_W  granted write data (0 for reads).
- out_ready  in  1  scheduler accepts out_cmd this cycle.
- idle  out  1  all FIFOs empty.
- ovf_err  out  1  sticky: a command was presented to a full bank.

Behaviour:
- Reset (synchronous, power_on_rst=1 at a rising edge):
  - all counts, pointers and RR pointer go to 0; ovf_err=0.
  - Outputs after reset: ba_cmd_pm=all 1s, out_valid=0, out_cmd=0, out_wdata=0, idle=1.
  - Reset asserted mid-operation discards all buffered commands in that same edge.
- Per-bank state: count[b] (0..DEPTH), wr_ptr[b], rd_ptr[b], each wrapping modulo DEPTH.
- ba_cmd_pm[b] = (count[b] != DEPTH). It is combinational from registered count, so it is stable through the cycle.
- Push: on valid=1, b = command[2:0].
  - If ba_cmd_pm[b]=1: store {command, rw ? 0 : write_data} at wr_ptr[b], then wr_ptr[b]++ and count[b]++.
  - If ba_cmd_pm[b]=0: the command is dropped, ovf_err<=1 (cleared only by reset), and no state changes.
  - A push to a full bank is rejected even if that bank is popped in the same cycle.
- Arbitration (combinational):
  - Search banks starting at rr_ptr, ascending with wrap, for the first with count>0.
  - out_valid=1 if any bank is non-empty; out_cmd/out_wdata = that bank's head entry.
  - If all banks are empty, out_cmd=0 and out_wdata=0.
- Pop: on out_valid && out_ready:
  - rd_ptr[g]++ and count[g]-- for granted bank g.
  - rr_ptr <= (g+1) mod NUM_BANKS.
  - rr_ptr does not move without a pop; the grant stays stable while out_ready=0 unless a higher-priority bank becomes non-empty.
- Simultaneous push and pop on the same non-full bank: count unchanged, both pointers advance.
- Latency: a command pushed at edge t can appear on out_cmd after edge t (visible in cycle t+1), with no bypass in the same cycle.
- Ordering: FIFO order is preserved within a bank; no ordering is guaranteed across banks.
- idle = all count[b]==0.
- The rank field is carried through unmodified and is not used for routing.

Test Plan:
- Reset → ba_cmd_pm=8'hFF, out_valid=0, idle=1, ovf_err=0; hold power_on_rst for 3 cycles and require identical outputs.
- With out_ready=0, push 4 writes to bank 2 (row 0..3, data 128'hA0..A3) → ba_cmd_pm=8'hFB. A 5th push sets ovf_err=1. Then raise out_ready → rows 0,1,2,3 emerge in order with data A0..A3; idle=1 after the 4th pop.
- Push one read each to banks 0, 1, 3, 7 in a single burst, with out_ready=1 from then on → grants in order 0,1,3,7, and every read has out_wdata=0.
- rr_ptr=1 after a bank-0 pop; banks 0 and 1 non-empty → bank 1 granted first, then bank 0.
- Bank 5 full, out_ready=1 popping bank 5 while valid pushes to bank 5 → push rejected and ovf_err=1, count goes 4→3. Next cycle ba_cmd_pm[5]=1 and a push is accepted.
- Load 3 entries across banks, then assert power_on_rst for one cycle mid-stream → next cycle out_valid=0, idle=1, and no stale command emerges after subsequent pushes.
